// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // True when exactly one bit of v is set.
  function automatic logic onehot_chk(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Encode a one-hot row vector to its bit position (0 when empty).
  function automatic logic [2:0] row_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous keypad row lines.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability stage followed by the resolved stage.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner_param.sv
// Matrix-keypad scanner: one-hot column drive, debounced press/release,
// single-key strobe with hold/release status and a multi-key indication.
module keypad_scanner_param
  import keypad_pkg::*;
#(
  parameter int N_ROWS        = 4,
  parameter int N_COLS        = 4,
  parameter int DWELL_CYCLES  = 262144,
  parameter int SETTLE_CYCLES = 16,
  parameter int DB_CYCLES     = 65536,
  parameter int KEY_W         = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [N_ROWS-1:0] rows_raw,
  output logic [N_COLS-1:0] columns,
  output logic [KEY_W-1:0]  key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int CI_W = $clog2(N_COLS);
  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [N_ROWS-1:0] rows_sync;

  scan_state_t       state_q,       state_d;
  logic [CI_W-1:0]   col_idx_q,     col_idx_d;
  logic [DW_W-1:0]   dwell_cnt_q,   dwell_cnt_d;
  logic [DB_W-1:0]   db_cnt_q,      db_cnt_d;
  logic [DB_W-1:0]   rel_cnt_q,     rel_cnt_d;
  logic [N_ROWS-1:0] cap_rows_q,    cap_rows_d;
  logic [KEY_W-1:0]  key_code_q,    key_code_d;
  logic              key_valid_q,   key_valid_d;
  logic              key_held_q,    key_held_d;
  logic              key_release_q, key_release_d;
  logic              multi_key_q,   multi_key_d;
  logic [CI_W-1:0]   col_next;

  keypad_sync #(.W(N_ROWS)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (rows_raw),
    .q       (rows_sync)
  );

  // Column index after the current one, wrapping at the last column.
  always_comb begin
    col_next = col_idx_q + 1'b1;
    if (col_idx_q == CI_W'(N_COLS - 1)) col_next = '0;
  end

  // Scan / debounce / held sequencing and strobe generation.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    dwell_cnt_d   = dwell_cnt_q;
    db_cnt_d      = db_cnt_q;
    rel_cnt_d     = rel_cnt_q;
    cap_rows_d    = cap_rows_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    multi_key_d   = 1'b0;
    // Held rises the cycle after the accept strobe.
    key_held_d    = key_held_q | key_valid_q;

    case (state_q)
      SCAN: begin
        if (dwell_cnt_q >= DW_W'(SETTLE_CYCLES) && rows_sync != '0) begin
          cap_rows_d = rows_sync;
          db_cnt_d   = DB_W'(1);
          state_d    = DEBOUNCE;
        end else if (dwell_cnt_q == DW_W'(DWELL_CYCLES - 1)) begin
          col_idx_d   = col_next;
          dwell_cnt_d = '0;
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rows_sync != cap_rows_q) begin
          // Bounce: drop the candidate silently and move on.
          col_idx_d   = col_next;
          dwell_cnt_d = '0;
          db_cnt_d    = '0;
          state_d     = SCAN;
        end else if (db_cnt_q >= DB_W'(DB_CYCLES - 1)) begin
          db_cnt_d  = DB_W'(DB_CYCLES);
          rel_cnt_d = '0;
          state_d   = HELD;
          if (onehot_chk(8'(cap_rows_q))) begin
            key_code_d  = KEY_W'(row_index(8'(cap_rows_q))) * KEY_W'(N_COLS)
                        + KEY_W'(col_idx_q);
            key_valid_d = 1'b1;
          end else begin
            multi_key_d = 1'b1;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        // Pattern changes while held are ignored; only all-clear counts.
        if (rows_sync == '0) begin
          if (rel_cnt_q >= DB_W'(DB_CYCLES - 1)) begin
            key_release_d = 1'b1;
            key_held_d    = 1'b0;
            col_idx_d     = col_next;
            dwell_cnt_d   = '0;
            db_cnt_d      = '0;
            rel_cnt_d     = '0;
            state_d       = SCAN;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end else begin
          rel_cnt_d = '0;
        end
      end

      default: begin
        state_d     = SCAN;
        dwell_cnt_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= SCAN;
      col_idx_q     <= '0;
      dwell_cnt_q   <= '0;
      db_cnt_q      <= '0;
      rel_cnt_q     <= '0;
      cap_rows_q    <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
      multi_key_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      dwell_cnt_q   <= dwell_cnt_d;
      db_cnt_q      <= db_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      cap_rows_q    <= cap_rows_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
      multi_key_q   <= multi_key_d;
    end
  end

  assign columns     = N_COLS'(1) << col_idx_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;
  assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Scoreboard bench for keypad_scanner_param driven by a 4x4 key-matrix model.
module tb_keypad_scanner_param;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_REL   = 2'd1;
  localparam logic [1:0] K_MULTI = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [3:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] rows_raw;
  logic [3:0] columns;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_release, multi_key;

  logic [3:0][3:0] pressed;   // pressed[row][col]
  exp_t            exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  // Keypad matrix: a row reads high when a pressed key sits in a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) rows_raw[r] = |(pressed[r] & columns);
  end

  keypad_scanner_param #(
    .N_ROWS(4), .N_COLS(4), .DWELL_CYCLES(16), .SETTLE_CYCLES(2), .DB_CYCLES(8)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rows_raw    (rows_raw),
    .columns     (columns),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] k;
    if (n_reset && (key_valid || key_release || multi_key)) begin
      n_vec++;
      k = key_valid ? K_VALID : (key_release ? K_REL : K_MULTI);
      if ((32'(key_valid) + 32'(key_release) + 32'(multi_key)) != 1) begin
        n_err++;
        $display("FAIL strobe_excl: got v=%0b r=%0b m=%0b want exactly one",
                 key_valid, key_release, multi_key);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got kind=%0d code=%0d want none", k, key_code);
      end else begin
        e = exp_q.pop_front();
        if (k != e.kind || (k != K_REL && key_code != e.code)) begin
          n_err++;
          $display("FAIL strobe: got kind=%0d code=%0d want kind=%0d code=%0d",
                   k, key_code, e.kind, e.code);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] code);
    exp_t e;
    e.kind = kind;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_held(input logic v, input int max);
    int n = 0;
    while (key_held !== v && n < max) begin @(negedge clk); n++; end
    chk("wait_held", int'(key_held), int'(v));
  endtask

  task automatic wait_col(input logic [3:0] c, input int max);
    int n = 0;
    while (columns !== c && n < max) begin @(negedge clk); n++; end
    chk("wait_col", int'(columns), int'(c));
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin @(negedge clk); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_columns"}, int'(columns), 1);
    chk({tag, "_code"},    int'(key_code), 0);
    chk({tag, "_strobes"}, int'({key_valid, key_held, key_release, multi_key}), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int left;
    pressed = '0;
    n_reset = 1'b0;
    #3;
    chk_reset_outputs("reset");
    #4 n_reset = 1'b1;   // time 7: between posedges 5 and 15

    // 1: idle scan, 16 cycles per column, no strobes.
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      chk("idle_columns", int'(columns), 1 << ((k / 16) % 4));
    end

    // 2: single key row 2 / col 1 -> code 9, then release -> next column.
    pressed[2][1] = 1'b1;
    push(K_VALID, 4'd9);
    wait_held(1'b1, 200);
    chk("s2_code", int'(key_code), 9);
    wait_drain(5);
    pressed = '0;
    push(K_REL, 4'd0);
    wait_held(1'b0, 100);
    chk("s2_columns", int'(columns), 4'b0100);
    wait_drain(5);

    // 3: bouncing row 0 in column 0 -> abort and move to column 1.
    wait_col(4'b0001, 100);
    left = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc % 3 == 0) pressed[0][0] = ~pressed[0][0];
      @(negedge clk);
      if (columns != 4'b0001) begin left = cyc + 1; break; end
    end
    pressed = '0;
    chk("s3_next_col", int'(columns), 4'b0010);
    chk("s3_left_soon", int'(left > 0 && left <= 24), 1);
    idle(20);

    // 4: rows 0+3 in column 2 -> multi strobe, code kept, no hold.
    pressed[0][2] = 1'b1;
    pressed[3][2] = 1'b1;
    push(K_MULTI, 4'd9);
    wait_drain(200);
    idle(3);
    chk("s4_held", int'(key_held), 0);
    chk("s4_code", int'(key_code), 9);
    pressed = '0;
    push(K_REL, 4'd0);
    wait_drain(100);

    // 5: key row 1 / col 3 -> code 7; adding row 2 while held changes nothing.
    pressed[1][3] = 1'b1;
    push(K_VALID, 4'd7);
    wait_held(1'b1, 200);
    wait_drain(5);
    pressed[2][3] = 1'b1;
    idle(30);
    chk("s5_code", int'(key_code), 7);
    chk("s5_held", int'(key_held), 1);
    pressed = '0;
    push(K_REL, 4'd0);
    wait_drain(100);
    chk("s5_held_off", int'(key_held), 0);

    // 6a: reset while debouncing key 0/0.
    wait_col(4'b0010, 100);
    pressed[0][0] = 1'b1;
    wait_col(4'b0001, 100);
    idle(5);
    #2 n_reset = 1'b0;
    #1 chk_reset_outputs("rst_db");
    pressed = '0;
    idle(3);
    n_reset = 1'b1;
    idle(40);

    // 6b: reset while holding key 1/0 (code 4).
    pressed[1][0] = 1'b1;
    push(K_VALID, 4'd4);
    wait_held(1'b1, 200);
    wait_drain(5);
    #2 n_reset = 1'b0;
    #1 chk_reset_outputs("rst_held");
    pressed = '0;
    idle(3);
    n_reset = 1'b1;
    idle(40);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
